serial_subtract_ctrl: RTL and testbench
=======================================

Name: serial_subtract_ctrl

Overview:
Bit-serial N-bit subtractor controller. It sequences a single 1-bit full-subtract stage, built from two half-subtract cells and a borrow register, over WIDTH cycles, LSB first. Operands enter through a valid/ready handshake and the result leaves through a second valid/ready handshake. It is the sequencer that turns the team's 1-bit subtract cells into a multi-bit subtract resource for the datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1 to 64.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset; deassertion is synchronised externally
in_valid  input  1  operands a/b are valid
in_ready  output  1  controller can accept operands
a  input  WIDTH  minuend (unsigned)
b  input  WIDTH  subtrahend (unsigned)
abort  input  1  synchronous cancel of an in-flight operation
out_valid  output  1  diff/borrow are valid
out_ready  input  1  consumer takes the result
diff  output  WIDTH  (a - b) mod 2^WIDTH
borrow  output  1  final borrow; 1 iff a < b (unsigned)
busy  output  1  high in RUN

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. Reset values: in_ready=1, out_valid=0, busy=0, diff=0, borrow=0. Also cleared: operand shift registers, borrow register, bit counter.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - in_valid=1 at an edge: capture a and b into shift registers, clear borrow register, set counter to 0, go to RUN.
  - in_valid=0: stay in IDLE.
- RUN: busy=1, in_ready=0. Each cycle, with a0/b0 the shift-register LSBs and br the borrow register:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d shifts into the diff register from the MSB side; the operand registers shift right; counter increments.
  - When counter == WIDTH-1 (the last bit is processed at this edge), go to DONE. diff then holds the full result and borrow = br_next.
- Latency: handshake at edge k; out_valid=1 after edge k+WIDTH, i.e. exactly WIDTH RUN cycles.
- DONE: out_valid=1, in_ready=0. diff and borrow are held stable while out_ready=0.
  - out_valid & out_ready at an edge: go to IDLE, out_valid=0. diff/borrow keep their value (don't-care once out_valid=0).
  - A new operand pair cannot be accepted until the cycle after the result handshake. Maximum throughput is one result per WIDTH+2 cycles.
- abort:
  - In RUN: go to IDLE at the next edge, no out_valid pulse, borrow register cleared.
  - In IDLE or DONE: ignored. A DONE result is never discarded by abort.
  - abort has priority over completion when both occur on the last RUN cycle.
- in_valid during RUN/DONE: ignored (in_ready=0); the upstream holds its data.
- WIDTH=1: RUN lasts one cycle. diff = a^b, borrow = ~a & b.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; the partial result is lost.
- Signals sampled at an edge are treated as already known; outputs are registered; no combinational path from inputs to outputs except none (in_ready is a decode of state only).

Test Plan:
1. WIDTH=8, a=0x5A, b=0x23, out_ready=1 -> out_valid rises exactly 8 cycles after accept; diff=0x37, borrow=0; in_ready returns 1 the cycle after the handshake.
2. a=0x10, b=0x20 -> diff=0xF0, borrow=1. a=0x00, b=0x01 -> diff=0xFF, borrow=1. a=b=0xFF -> diff=0x00, borrow=0.
3. Backpressure: a=0x80, b=0x01, out_ready held 0 for 5 cycles after out_valid -> diff=0x7F and borrow=0 stay stable, in_ready=0 throughout; in_valid pulses during the stall are ignored; handshake on the 6th cycle -> IDLE.
4. Abort: start a=0xC3, b=0x3C, assert abort on the 4th RUN cycle -> IDLE next edge, no out_valid. The next op a=0x03, b=0x01 -> diff=0x02, borrow=0 (no stale borrow carried over).
5. Reset mid-operation: drop rst_n on the 3rd RUN cycle -> all outputs at reset values asynchronously; after release, in_ready=1 and a fresh op a=0x01, b=0x02 -> diff=0xFF, borrow=1.
6. Random regression: 1000 random pairs with random out_ready stalls, for WIDTH in {1, 8, 16} -> diff and borrow match a reference model; latency is always WIDTH.

Source files
------------

// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl: bit-serial WIDTH-bit unsigned subtractor, LSB first, with
// valid/ready handshakes on operands and result, abort and async active-low reset.
module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0] cnt;
    logic d, br_nx, last;
    // Two cascaded half-subtract cells plus the borrow register form the full-subtract stage
    assign d     = sa[0] ^ sb[0] ^ borrow;
    assign br_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
    assign last  = cnt == CW'(WIDTH - 1);
    always_comb begin
        state_nx  = state;
        state_nx  = state == IDLE ? (in_valid ? RUN : IDLE) :
                    state == RUN  ? (abort ? IDLE : (last ? DONE : RUN)) :
                                    (out_ready ? IDLE : DONE);
        in_ready  = state == IDLE;
        busy      = state == RUN;
        out_valid = state == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                sa     <= a;
                sb     <= b;
                borrow <= 1'b0;
                cnt    <= '0;
            end else if (state == RUN && abort) begin
                borrow <= 1'b0;
            end else if (state == RUN) begin
                sa     <= sa >> 1;
                sb     <= sb >> 1;
                diff   <= (diff >> 1) | (WIDTH'(d) << (WIDTH - 1));
                borrow <= br_nx;
                cnt    <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// tb_serial_subtract_ctrl: directed and randomized checks of serial_subtract_ctrl at
// WIDTH 1, 8 and 16 against a transaction-level model of the subtract resource.
module tb_serial_subtract_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] a_s[3], b_s[3], dif[3];
    logic iv[3], ab[3], ordy[3], ir[3], ov[3], bor[3], bsy[3];
    int errors = 0, checks = 0;
    bit free[3] = '{1'b1, 1'b1, 1'b1};
    longint cyc = 0;
    longint t_done[3];
    logic [15:0] ed[3];
    logic eb[3];
    int res_cnt[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W = g == 0 ? 1 : (g == 1 ? 8 : 16);
        logic [W-1:0] d_w;
        serial_subtract_ctrl #(.WIDTH(W)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]),
            .a(a_s[g][W-1:0]), .b(b_s[g][W-1:0]), .abort(ab[g]),
            .out_valid(ov[g]), .out_ready(ordy[g]), .diff(d_w),
            .borrow(bor[g]), .busy(bsy[g])
        );
        assign dif[g] = 16'(d_w);
    end

    function automatic int wid(input int i);
        return i == 0 ? 1 : (i == 1 ? 8 : 16);
    endfunction

    function automatic logic [15:0] msk(input int i);
        logic [16:0] m;
        m = (17'd1 << wid(i)) - 17'd1;
        return m[15:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction model: an accepted pair yields (a-b) mod 2^W exactly W edges later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) free[i] <= 1'b1;
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 3; i++) begin
                if (free[i]) begin
                    if (iv[i]) begin
                        free[i]   <= 1'b0;
                        t_done[i] <= cyc + 1 + wid(i);
                        ed[i]     <= (a_s[i] - b_s[i]) & msk(i);
                        eb[i]     <= (a_s[i] & msk(i)) < (b_s[i] & msk(i));
                    end
                end else if (cyc < t_done[i]) begin
                    if (ab[i]) free[i] <= 1'b1;
                end else if (ordy[i]) begin
                    free[i]    <= 1'b1;
                    res_cnt[i] <= res_cnt[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                logic eov;
                eov = !free[i] && cyc >= t_done[i];
                chk($sformatf("in_ready[w%0d]", wid(i)), 64'(ir[i]), 64'(free[i]));
                chk($sformatf("out_valid[w%0d]", wid(i)), 64'(ov[i]), 64'(eov));
                chk($sformatf("busy[w%0d]", wid(i)), 64'(bsy[i]), 64'(!free[i] && !eov));
                if (eov) begin
                    chk($sformatf("diff[w%0d]", wid(i)), 64'(dif[i]), 64'(ed[i]));
                    chk($sformatf("borrow[w%0d]", wid(i)), 64'(bor[i]), 64'(eb[i]));
                end
            end
        end
    end

    task automatic start(input logic [15:0] x, input logic [15:0] y, input logic rdy);
        @(posedge clk); #1;
        a_s[1] = x; b_s[1] = y; iv[1] = 1'b1; ordy[1] = rdy;
        @(posedge clk); #1;
        iv[1] = 1'b0;
    endtask

    task automatic op(input logic [15:0] x, input logic [15:0] y, input logic [15:0] edx,
                      input logic ebx, input int stall, input string nm);
        int n;
        start(x, y, stall == 0);
        n = 0;
        while (!ov[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_timeout"}, 64'(n < 100), 64'(1));
        chk({nm, "_diff"}, 64'(dif[1]), 64'(edx));
        chk({nm, "_borrow"}, 64'(bor[1]), 64'(ebx));
        repeat (stall) begin
            @(posedge clk); #1;
            iv[1] = 1'(($urandom % 2));
            a_s[1] = 16'($urandom);
            b_s[1] = 16'($urandom);
        end
        if (stall > 0) begin
            chk({nm, "_held_diff"}, 64'(dif[1]), 64'(edx));
            chk({nm, "_held_ready"}, 64'(ir[1]), 64'(0));
        end
        iv[1] = 1'b0;
        ordy[1] = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        longint budget;
        for (int i = 0; i < 3; i++) begin
            a_s[i] = '0; b_s[i] = '0; iv[i] = 1'b0; ab[i] = 1'b0; ordy[i] = 1'b1;
        end
        #1;
        chk("rst_in_ready", 64'(ir[1]), 64'(1));
        chk("rst_out_valid", 64'(ov[1]), 64'(0));
        chk("rst_busy", 64'(bsy[1]), 64'(0));
        chk("rst_diff", 64'(dif[1]), 64'(0));
        chk("rst_borrow", 64'(bor[1]), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        op(16'h5A, 16'h23, 16'h37, 1'b0, 0, "basic");
        op(16'h10, 16'h20, 16'hF0, 1'b1, 0, "neg");
        op(16'h00, 16'h01, 16'hFF, 1'b1, 0, "zero_minus_one");
        op(16'hFF, 16'hFF, 16'h00, 1'b0, 0, "equal");
        op(16'h80, 16'h01, 16'h7F, 1'b0, 5, "stall");

        start(16'hC3, 16'h3C, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        ab[1] = 1'b1;
        @(posedge clk); #1;
        ab[1] = 1'b0;
        chk("abort_idle", 64'(ir[1]), 64'(1));
        repeat (12) @(posedge clk);
        #1;
        op(16'h03, 16'h01, 16'h02, 1'b0, 0, "after_abort");

        start(16'h55, 16'h11, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(ir[1]), 64'(1));
        chk("mid_rst_out_valid", 64'(ov[1]), 64'(0));
        chk("mid_rst_busy", 64'(bsy[1]), 64'(0));
        chk("mid_rst_diff", 64'(dif[1]), 64'(0));
        chk("mid_rst_borrow", 64'(bor[1]), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 64'(ir[1]), 64'(1));
        op(16'h01, 16'h02, 16'hFF, 1'b1, 0, "after_reset");

        budget = 0;
        for (int i = 0; i < 3; i++) res_cnt[i] = 0;
        while ((res_cnt[0] < 1000 || res_cnt[1] < 1000 || res_cnt[2] < 1000) && budget < 60000) begin
            @(posedge clk); #1;
            budget++;
            for (int i = 0; i < 3; i++) begin
                iv[i]   = 1'(($urandom % 2));
                a_s[i]  = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
                b_s[i]  = ($urandom % 8 == 0) ? 16'h0000 : 16'($urandom);
                ordy[i] = ($urandom % 4) != 0;
                ab[i]   = ($urandom % 64) == 0;
            end
        end
        chk("random_budget", 64'(budget < 60000), 64'(1));
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ab[i] = 1'b0; ordy[i] = 1'b1;
        end
        repeat (20) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
